// File: rtl/uart_defs.sv
// Shared UART definitions: receiver state encoding, frame constants and the baud divider helper.
package uart_defs;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, never below one.
  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO with wrap-bit pointers; a write into a full FIFO is
// accepted only when a read retires the head in the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int DEPTH = 1 << AW;

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd, do_wr;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wptr_q[AW-1:0]] <= wr_data_i;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled frame FSM feeding a show-ahead receive FIFO.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | validating start bit at its midpoint
// DATA      | sampling eight data bits, LSB first
// STOP      | sampling stop bit; push byte or flag framing error
// WAIT_HIGH | broken frame, waiting for line to return high
module uart_rx
  import uart_defs::*;
#(
  parameter int SYS_CLK_FREQ = 100000000,
  parameter int BAUD_RATE    = 115200,
  parameter int FIFO_AW      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV   = calc_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  rx_state_e            state_q;
  logic [1:0]           sync_q;
  logic [DIV_W-1:0]     div_q;
  logic [CNT_W-1:0]     tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 push_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_s;
  logic                 tick;
  logic                 half_bit;
  logic                 full_bit;

  assign rx_s     = sync_q[1];
  assign tick     = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));
  assign half_bit = (tick_cnt_q == CNT_W'(OVERSAMPLE / 2 - 1));
  assign full_bit = (tick_cnt_q == CNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      div_q       <= '0;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;

      // Divider parks at zero in IDLE so START always begins a fresh tick period.
      if (state_q == IDLE || tick) div_q <= '0;
      else                         div_q <= div_q + DIV_W'(1);

      case (state_q)
        IDLE: begin
          tick_cnt_q <= '0;
          bit_cnt_q  <= '0;
          if (!rx_s) state_q <= START;
        end
        START: begin
          if (tick) begin
            if (half_bit) begin
              tick_cnt_q <= '0;
              state_q    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (full_bit) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + BIT_W'(1);
              if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) state_q <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (full_bit) begin
              tick_cnt_q <= '0;
              if (rx_s) begin
                push_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                frame_err_q <= 1'b1;
                state_q     <= WAIT_HIGH;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + CNT_W'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A push into a full FIFO survives only if the head is popped in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= push_q && full && !rd_en;
  end

  fifo #(
    .WIDTH(DATA_BITS),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_en_i  (push_q),
    .wr_data_i(shift_q),
    .rd_en_i  (rd_en),
    .rd_data_o(dout),
    .empty_o  (empty),
    .full_o   (full)
  );

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clk per bit: a frame-level scoreboard checked every cycle,
// plus literal expectations for each directed scenario.
module tb_uart_rx;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  // Falling edge of start bit to first visible FIFO entry: 2 sync flops,
  // stop sampled 9.5 bits in, one registered push.
  localparam int BYTE_LAT = 156;
  localparam int FERR_LAT = 155;

  logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty, full, frame_err, overrun;

  uart_rx #(.SYS_CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .dout(dout),
    .empty(empty), .full(full), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] b;
    bit         ferr;
  } ev_t;

  ev_t        pend[$];
  logic [7:0] mq[$];
  int         cyc = 0;
  bit         exp_ferr = 0, exp_ovr = 0;
  int         checks = 0, errors = 0;
  int         ferr_seen = 0, ovr_seen = 0;

  task automatic chk1(input string n, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", n, act, req, cyc);
    end
  endtask

  task automatic chk8(input string n, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  task automatic chki(input string n, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // Frame-level model: bytes land BYTE_LAT cycles after the start edge.
  always @(posedge clk) begin : model
    bit  was_full;
    ev_t e;
    cyc      = cyc + 1;
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    if (rst) begin
      pend.delete();
      mq.delete();
    end else begin
      was_full = (mq.size() == 8);
      if (rd_en && mq.size() > 0) void'(mq.pop_front());
      while (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        if (e.ferr)                 exp_ferr = 1'b1;
        else if (was_full && !rd_en) exp_ovr = 1'b1;
        else                        mq.push_back(e.b);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk1("rst_empty", empty, 1'b1);
      chk1("rst_full", full, 1'b0);
      chk1("rst_frame_err", frame_err, 1'b0);
      chk1("rst_overrun", overrun, 1'b0);
      chk8("rst_dout", dout, 8'h00);
    end else begin
      chk1("empty", empty, mq.size() == 0);
      chk1("full", full, mq.size() == 8);
      if (mq.size() > 0) chk8("dout", dout, mq[0]);
      chk1("frame_err", frame_err, exp_ferr);
      chk1("overrun", overrun, exp_ovr);
    end
    if (frame_err) ferr_seen++;
    if (overrun)   ovr_seen++;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok);
    int  s;
    ev_t e;
    @(posedge clk);
    #1;
    s  = cyc;
    rx = 1'b0;
    hold(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      hold(16);
    end
    e.b    = b;
    e.ferr = !stop_ok;
    e.due  = stop_ok ? s + BYTE_LAT : s + FERR_LAT;
    pend.push_back(e);
    rx = stop_ok;
    hold(16);
    rx = 1'b1;
  endtask

  task automatic pop(input string n, input logic [7:0] req);
    chk1({n, "_not_empty"}, empty, 1'b0);
    chk8(n, dout, req);
    rd_en = 1'b1;
    hold(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    hold(4);
    rst = 1'b0;
    hold(5);

    // single byte, pop, then a pop on empty
    send(8'hA5, 1'b1);
    hold(2);
    chk1("a5_empty", empty, 1'b0);
    pop("a5_pop", 8'hA5);
    chk1("a5_empty_after", empty, 1'b1);
    rd_en = 1'b1;
    hold(2);
    rd_en = 1'b0;
    chk1("pop_on_empty", empty, 1'b1);

    // back-to-back frames
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    hold(2);
    pop("b2b_0", 8'h00);
    pop("b2b_1", 8'hFF);
    pop("b2b_2", 8'h3C);
    chki("b2b_no_ferr", ferr_seen, 0);
    chki("b2b_no_ovr", ovr_seen, 0);

    // short low glitch is a false start
    rx = 1'b0;
    hold(4);
    rx = 1'b1;
    hold(200);
    chk1("glitch_empty", empty, 1'b1);
    chki("glitch_no_ferr", ferr_seen, 0);

    // framing error then recovery
    send(8'h55, 1'b0);
    hold(20);
    chki("ferr_count", ferr_seen, 1);
    chk1("ferr_empty", empty, 1'b1);
    send(8'h12, 1'b1);
    hold(2);
    pop("after_ferr", 8'h12);

    // fill to full, ninth byte overruns
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b1);
    hold(2);
    chk1("fill_full", full, 1'b1);
    chki("ovr_count", ovr_seen, 1);

    // push into full FIFO with simultaneous pop
    fork
      send(8'h0A, 1'b1);
      begin
        @(posedge clk);
        #1;
        hold(BYTE_LAT - 1);
        chk8("simul_head", dout, 8'h01);
        rd_en = 1'b1;
        hold(1);
        rd_en = 1'b0;
      end
    join
    hold(2);
    chki("simul_no_ovr", ovr_seen, 1);
    chk1("simul_full", full, 1'b1);
    for (int i = 2; i <= 8; i++) pop("drain", 8'(i));
    pop("drain_last", 8'h0A);
    chk1("drain_empty", empty, 1'b1);

    // reset during bit 3 of 0x77
    @(posedge clk);
    #1;
    rx = 1'b0;
    hold(16);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1) ? 1'b1 : 1'b1;
      hold(16);
    end
    rx = 1'b0;
    hold(8);
    rst = 1'b1;
    rx  = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(20);
    chk1("abort_empty", empty, 1'b1);
    send(8'h42, 1'b1);
    hold(2);
    pop("after_rst", 8'h42);
    chk1("after_rst_empty", empty, 1'b1);

    hold(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYS_CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate in bits/s.
REQ-003 SHALL have parameter FIFO_AW, default 3, meaning the log2 of the receive FIFO depth (8 entries).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1 format, idle high.
REQ-007 SHALL have port rd_en, input, 1 bit: pops the FIFO head on a clk edge where empty=0.
REQ-008 SHALL have port dout, output, 8 bits: the FIFO head byte (show-ahead), valid while empty=0.
REQ-009 SHALL have port empty, output, 1 bit: asserted when the FIFO holds 0 bytes.
REQ-010 SHALL have port full, output, 1 bit: asserted when the FIFO holds 2^FIFO_AW bytes.
REQ-011 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a received byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer with reset value 1; all other logic uses only the synchronized value.
REQ-014 SHALL generate a tick every DIV = SYS_CLK_FREQ/(BAUD_RATE*16) clk cycles (integer division, DIV>=1); the divider runs only outside IDLE and restarts at 0 on entry to START.
REQ-015 SHALL implement the FSM states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: on synchronized rx=0, SHALL go to START.
REQ-017 START: at tick 8, SHALL sample the line; if 1 (false start), go to IDLE; if 0, go to DATA with the tick count reset.
REQ-018 DATA: SHALL sample one bit every 16 ticks, shift it in LSB first, and go to STOP after bit 7.
REQ-019 STOP: at tick 16, SHALL sample the line; if 1, present the byte for push and go to IDLE; if 0, pulse frame_err, discard the byte, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH: SHALL remain until synchronized rx=1, then go to IDLE.
REQ-021 On a push, SHALL clear empty on the clk edge following the stop-sample edge.
REQ-022 If a push occurs while full=1 and rd_en=0, SHALL drop the byte, pulse overrun for 1 cycle, and leave the FIFO unchanged.
REQ-023 If a push occurs while full=1 and rd_en=1 in the same cycle, SHALL perform both the pop and the push; no overrun.
REQ-024 rd_en while empty=1 SHALL be ignored, with no pointer change.
REQ-025 SHALL use FIFO pointers of FIFO_AW+1 bits that wrap modulo 2^(FIFO_AW+1); full/empty derive from the MSB compare.
REQ-026 frame_err and overrun SHALL never be asserted for more than 1 consecutive cycle per event.

Reset
REQ-027 While rst=1, SHALL hold: FSM=IDLE, synchronizer=11, divider/bit counters=0, FIFO pointers=0, empty=1, full=0, frame_err=0, overrun=0, dout=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and push nothing; after release, reception SHALL resume at the next falling edge.

Structure
REQ-029 SHALL place the FSM state encodings and the constants DATA_BITS=8 and OVERSAMPLE=16 in the shared header uart_defs.
REQ-030 SHALL implement the FIFO as sub-module fifo (parameters WIDTH, AW), also reused by the future transmitter.

Verification
Benches SHALL use SYS_CLK_FREQ=1600000 and BAUD_RATE=100000, giving DIV=1 and 16 clk per bit.
REQ-031 Send 0xA5 -> empty falls after about 160 clk; dout=0xA5; rd_en for 1 cycle -> empty=1.
REQ-032 Send 0x00, 0xFF, 0x3C back-to-back -> popped in order 0x00, 0xFF, 0x3C; no error pulses.
REQ-033 Low glitch of 4 clk on rx -> FSM returns to IDLE; empty stays 1.
REQ-034 Send 0x55 with stop bit low -> one frame_err pulse; empty stays 1; the next valid 0x12 is received.
REQ-035 Send 9 bytes 0x01..0x09 with no reads -> full=1 after 0x08; one overrun pulse on 0x09; pops yield 0x01..0x08.
REQ-036 Assert rst during bit 3 of 0x77, then send 0x42 -> only 0x42 is received.
